// File: rtl/lc3_decode_stage.sv
// LC3 pipeline decode stage: registers IR/NPC and decodes execute, memory and writeback controls.
// Optional feature: define LC3_DECODE_ILLEGAL_DET_EN to add the illegal_op output.
module lc3_decode_stage #(
  parameter int unsigned PC_W   = 16,
  parameter logic [15:0] NOP_IR = 16'h0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable_decode,
  input  logic            flush,
  input  logic [15:0]     dout,
  input  logic [PC_W-1:0] npc_in,
`ifdef LC3_DECODE_ILLEGAL_DET_EN
  output logic            illegal_op,
`endif
  output logic [15:0]     IR,
  output logic [PC_W-1:0] npc_out,
  output logic [5:0]      E_control,
  output logic [1:0]      W_control,
  output logic            Mem_control,
  output logic            decode_valid
);

  localparam logic [3:0] OpBr  = 4'b0000;
  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpLd  = 4'b0010;
  localparam logic [3:0] OpSt  = 4'b0011;
  localparam logic [3:0] OpJsr = 4'b0100;
  localparam logic [3:0] OpAnd = 4'b0101;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpStr = 4'b0111;
  localparam logic [3:0] OpRti = 4'b1000;
  localparam logic [3:0] OpNot = 4'b1001;
  localparam logic [3:0] OpLdi = 4'b1010;
  localparam logic [3:0] OpSti = 4'b1011;
  localparam logic [3:0] OpJmp = 4'b1100;
  localparam logic [3:0] OpRes = 4'b1101;
  localparam logic [3:0] OpLea = 4'b1110;
  localparam logic [3:0] OpTrap = 4'b1111;

  logic [3:0] opcode;
  logic [1:0] alu_control;
  logic [1:0] pcselect1;
  logic       pcselect2;
  logic       op2select;
  logic [1:0] w_control_d;
  logic       mem_control_d;
  logic       illegal_d;

  assign opcode = dout[15:12];

  always_comb begin
    alu_control   = 2'b00;
    pcselect1     = 2'b00;
    pcselect2     = 1'b0;
    op2select     = 1'b0;
    w_control_d   = 2'b00;
    mem_control_d = 1'b0;
    illegal_d     = 1'b0;
    unique case (opcode)
      OpAdd: op2select = ~dout[5];
      OpAnd: begin
        alu_control = 2'b01;
        op2select   = ~dout[5];
      end
      OpNot: alu_control = 2'b10;
      OpBr, OpSt: begin
        pcselect1 = 2'b01;
        pcselect2 = 1'b1;
      end
      OpLd: begin
        pcselect1   = 2'b01;
        pcselect2   = 1'b1;
        w_control_d = 2'b01;
      end
      OpLdi: begin
        pcselect1     = 2'b01;
        pcselect2     = 1'b1;
        w_control_d   = 2'b01;
        mem_control_d = 1'b1;
      end
      OpSti: begin
        pcselect1     = 2'b01;
        pcselect2     = 1'b1;
        mem_control_d = 1'b1;
      end
      OpLea: begin
        pcselect1   = 2'b01;
        pcselect2   = 1'b1;
        w_control_d = 2'b10;
      end
      OpLdr: begin
        pcselect1   = 2'b10;
        w_control_d = 2'b01;
      end
      OpStr: pcselect1 = 2'b10;
      OpJmp: pcselect1 = 2'b11;
      // Unsupported opcodes load IR/NPC but carry no control activity.
      OpJsr, OpRti, OpRes, OpTrap: illegal_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      IR           <= NOP_IR;
      npc_out      <= '0;
      E_control    <= '0;
      W_control    <= '0;
      Mem_control  <= 1'b0;
      decode_valid <= 1'b0;
    end else if (flush) begin
      IR           <= NOP_IR;
      npc_out      <= '0;
      E_control    <= '0;
      W_control    <= '0;
      Mem_control  <= 1'b0;
      decode_valid <= 1'b0;
    end else if (enable_decode) begin
      IR           <= dout;
      npc_out      <= npc_in;
      E_control    <= {alu_control, pcselect1, pcselect2, op2select};
      W_control    <= w_control_d;
      Mem_control  <= mem_control_d;
      decode_valid <= 1'b1;
    end else begin
      decode_valid <= 1'b0;
    end
  end

`ifdef LC3_DECODE_ILLEGAL_DET_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal_op <= 1'b0;
    end else if (flush) begin
      illegal_op <= 1'b0;
    end else if (enable_decode) begin
      illegal_op <= illegal_d;
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = illegal_d;
`endif

endmodule

// File: tb/tb_lc3_decode_stage.sv
// Self-checking bench for lc3_decode_stage: directed vector table, reset corner case,
// and randomized traffic against an opcode-table reference model.
module tb_lc3_decode_stage;

  localparam int unsigned PC_W = 16;

  logic            clock;
  logic            reset;
  logic            enable_decode;
  logic            flush;
  logic [15:0]     dout;
  logic [PC_W-1:0] npc_in;
  logic [15:0]     IR;
  logic [PC_W-1:0] npc_out;
  logic [5:0]      E_control;
  logic [1:0]      W_control;
  logic            Mem_control;
  logic            decode_valid;
  logic            illegal_op;

  lc3_decode_stage #(
    .PC_W   (PC_W),
    .NOP_IR (16'h0000)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .flush         (flush),
    .dout          (dout),
    .npc_in        (npc_in),
`ifdef LC3_DECODE_ILLEGAL_DET_EN
    .illegal_op    (illegal_op),
`endif
    .IR            (IR),
    .npc_out       (npc_out),
    .E_control     (E_control),
    .W_control     (W_control),
    .Mem_control   (Mem_control),
    .decode_valid  (decode_valid)
  );

`ifndef LC3_DECODE_ILLEGAL_DET_EN
  assign illegal_op = 1'b0;
`endif

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: per-opcode control tables from the ISA description.
  logic [1:0] alu_tab [16];
  logic [1:0] ps1_tab [16];
  logic       ps2_tab [16];
  logic [1:0] w_tab   [16];
  logic       mem_tab [16];
  logic       ill_tab [16];

  logic [15:0]     m_ir;
  logic [PC_W-1:0] m_npc;
  logic [5:0]      m_ec;
  logic [1:0]      m_w;
  logic            m_mem;
  logic            m_dv;
  logic            m_ill;

  task automatic init_tables();
    for (int i = 0; i < 16; i++) begin
      alu_tab[i] = 2'b00; ps1_tab[i] = 2'b00; ps2_tab[i] = 1'b0;
      w_tab[i] = 2'b00; mem_tab[i] = 1'b0; ill_tab[i] = 1'b0;
    end
    alu_tab[5] = 2'b01;
    alu_tab[9] = 2'b10;
    foreach (ps1_tab[i]) begin
      if (i == 0 || i == 2 || i == 10 || i == 3 || i == 11 || i == 14) begin
        ps1_tab[i] = 2'b01;
        ps2_tab[i] = 1'b1;
      end
    end
    ps1_tab[6] = 2'b10; ps1_tab[7] = 2'b10; ps1_tab[12] = 2'b11;
    w_tab[2] = 2'b01; w_tab[6] = 2'b01; w_tab[10] = 2'b01; w_tab[14] = 2'b10;
    mem_tab[10] = 1'b1; mem_tab[11] = 1'b1;
    ill_tab[4] = 1'b1; ill_tab[8] = 1'b1; ill_tab[13] = 1'b1; ill_tab[15] = 1'b1;
  endtask

  task automatic model_reset();
    m_ir = 16'h0000; m_npc = '0; m_ec = '0; m_w = '0; m_mem = 0; m_dv = 0; m_ill = 0;
  endtask

  task automatic model_edge(input logic en, input logic fl, input logic [15:0] d,
                            input logic [PC_W-1:0] n);
    int op;
    op = int'(d[15:12]);
    if (fl) begin
      model_reset();
    end else if (en) begin
      m_ir  = d;
      m_npc = n;
      m_ec  = {alu_tab[op], ps1_tab[op], ps2_tab[op], (op == 1 || op == 5) ? ~d[5] : 1'b0};
      m_w   = w_tab[op];
      m_mem = mem_tab[op];
      m_dv  = 1'b1;
      m_ill = ill_tab[op];
    end else begin
      m_dv = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".IR"}, 32'(IR), 32'(m_ir));
    chk({tag, ".npc_out"}, 32'(npc_out), 32'(m_npc));
    chk({tag, ".E_control"}, 32'(E_control), 32'(m_ec));
    chk({tag, ".W_control"}, 32'(W_control), 32'(m_w));
    chk({tag, ".Mem_control"}, 32'(Mem_control), 32'(m_mem));
    chk({tag, ".decode_valid"}, 32'(decode_valid), 32'(m_dv));
`ifdef LC3_DECODE_ILLEGAL_DET_EN
    chk({tag, ".illegal_op"}, 32'(illegal_op), 32'(m_ill));
`endif
  endtask

  typedef struct {
    logic        en;
    logic        fl;
    logic [15:0] d;
    logic [15:0] n;
    logic [15:0] ir;
    logic [15:0] npc;
    logic [5:0]  ec;
    logic [1:0]  w;
    logic        mem;
    logic        dv;
    logic        ill;
  } vec_t;

  vec_t vecs [12];

  task automatic apply(input logic en, input logic fl, input logic [15:0] d,
                       input logic [PC_W-1:0] n);
    @(negedge clock);
    enable_decode = en;
    flush         = fl;
    dout          = d;
    npc_in        = n;
    model_edge(en, fl, d, n);
    @(posedge clock);
    #1;
  endtask

  initial begin
    init_tables();
    model_reset();
    vecs[0]  = '{1, 0, 16'h1283, 16'h3001, 16'h1283, 16'h3001, 6'b000001, 2'b00, 0, 1, 0};
    vecs[1]  = '{1, 0, 16'h52A5, 16'h3002, 16'h52A5, 16'h3002, 6'b010000, 2'b00, 0, 1, 0};
    vecs[2]  = '{1, 0, 16'hA005, 16'h3003, 16'hA005, 16'h3003, 6'b000110, 2'b01, 1, 1, 0};
    vecs[3]  = '{1, 0, 16'h697F, 16'h3004, 16'h697F, 16'h3004, 6'b001000, 2'b01, 0, 1, 0};
    vecs[4]  = '{0, 0, 16'h1234, 16'h3005, 16'h697F, 16'h3004, 6'b001000, 2'b01, 0, 0, 0};
    vecs[5]  = '{0, 0, 16'hF678, 16'h3006, 16'h697F, 16'h3004, 6'b001000, 2'b01, 0, 0, 0};
    vecs[6]  = '{0, 0, 16'h9ABC, 16'h3007, 16'h697F, 16'h3004, 6'b001000, 2'b01, 0, 0, 0};
    vecs[7]  = '{1, 1, 16'hE0FF, 16'h3008, 16'h0000, 16'h0000, 6'b000000, 2'b00, 0, 0, 0};
    vecs[8]  = '{1, 0, 16'hE0FF, 16'h3009, 16'hE0FF, 16'h3009, 6'b000110, 2'b10, 0, 1, 0};
    vecs[9]  = '{1, 0, 16'hF025, 16'h300A, 16'hF025, 16'h300A, 6'b000000, 2'b00, 0, 1, 1};
    vecs[10] = '{1, 0, 16'hC1C0, 16'h300B, 16'hC1C0, 16'h300B, 6'b001100, 2'b00, 0, 1, 0};
    vecs[11] = '{1, 0, 16'h9FFF, 16'h300C, 16'h9FFF, 16'h300C, 6'b100000, 2'b00, 0, 1, 0};

    // Reset is asynchronous: outputs valid before any clock edge.
    reset = 1'b1; enable_decode = 1'b0; flush = 1'b0; dout = 16'h1283; npc_in = 16'h3001;
    #2;
    check_model("reset_async");
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) begin
      apply(vecs[i].en, vecs[i].fl, vecs[i].d, vecs[i].n);
      chk($sformatf("vec%0d.IR", i), 32'(IR), 32'(vecs[i].ir));
      chk($sformatf("vec%0d.npc_out", i), 32'(npc_out), 32'(vecs[i].npc));
      chk($sformatf("vec%0d.E_control", i), 32'(E_control), 32'(vecs[i].ec));
      chk($sformatf("vec%0d.W_control", i), 32'(W_control), 32'(vecs[i].w));
      chk($sformatf("vec%0d.Mem_control", i), 32'(Mem_control), 32'(vecs[i].mem));
      chk($sformatf("vec%0d.decode_valid", i), 32'(decode_valid), 32'(vecs[i].dv));
`ifdef LC3_DECODE_ILLEGAL_DET_EN
      chk($sformatf("vec%0d.illegal_op", i), 32'(illegal_op), 32'(vecs[i].ill));
`endif
    end

    // Mid-cycle reset while holding a LEA, then resume on the first enabled edge.
    apply(1, 0, 16'hE0FF, 16'h4000);
    check_model("lea_load");
    enable_decode = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_model("reset_midcycle");
    enable_decode = 1'b1;
    dout          = 16'h1283;
    @(posedge clock);
    #1;
    check_model("reset_beats_enable");
    @(negedge clock);
    reset = 1'b0;
    enable_decode = 1'b0;
    #1;
    check_model("reset_released");
    apply(1, 0, 16'h1283, 16'h4001);
    check_model("resume");

    // Flush while holding (enable low) must still squash.
    apply(0, 1, 16'hA005, 16'h4002);
    check_model("flush_hold");

    for (int i = 0; i < 400; i++) begin
      logic en;
      logic fl;
      en = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 9) == 0);
      apply(en, fl, 16'($urandom), PC_W'($urandom));
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
